// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal conditional-branch predictor: 2-bit counter table plus an
// in-order queue of in-flight predictions checked against resolved outcomes.
module branch_predictor_gshare #(
    parameter int IDX_W  = 6,
    parameter int Q_W    = 3,
    parameter int GHR_W  = 4,
    parameter int GSHARE = 1
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            req_valid,
    input  logic [31:0]     req_pc,
    input  logic [31:0]     req_imm,
    output logic            req_ready,
    output logic            pred_taken,
    output logic [31:0]     pred_target,
    input  logic            res_valid,
    input  logic [31:0]     res_pc,
    input  logic            res_taken,
    output logic            predict_fail,
    output logic [31:0]     fail_addr,
    output logic [Q_W:0]    count
);
    localparam int DEPTH   = 1 << Q_W;
    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [Q_W-1:0] PTR_ONE = Q_W'(1);
    localparam logic [Q_W:0]   CNT_ONE = (Q_W+1)'(1);
    localparam logic [Q_W:0]   CNT_MAX = (Q_W+1)'(DEPTH);

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      alt;
        logic             pred;
        logic [IDX_W-1:0] ix;
        logic [GHR_W-1:0] hist;
    } entry_t;

    entry_t           queue [DEPTH];
    logic [1:0]       ctr [ENTRIES];
    logic [GHR_W-1:0] ghr;
    logic [Q_W-1:0]   front;
    logic [Q_W-1:0]   rear;

    logic [IDX_W-1:0] idx;
    logic [31:0]      taken_addr;
    logic [31:0]      fall_addr;
    entry_t           head;
    logic [1:0]       head_ctr;
    logic             match;
    logic             push;
    logic             pop;
    logic [GHR_W-1:0] ghr_push;
    logic [GHR_W-1:0] ghr_fix;

    generate
        if (GSHARE != 0) begin : g_gshare
            assign idx = req_pc[IDX_W+1:2] ^ IDX_W'(ghr);
        end else begin : g_bimodal
            assign idx = req_pc[IDX_W+1:2];
        end
    endgenerate

    assign taken_addr = req_pc + req_imm;
    assign fall_addr  = req_pc + 32'd4;
    assign head       = queue[front];
    assign head_ctr   = ctr[head.ix];

    // Shift-in via truncating cast so GHR_W == 1 needs no special case.
    assign ghr_push = GHR_W'({ghr, pred_taken});
    assign ghr_fix  = GHR_W'({head.hist, res_taken});

    // Request side: an entry is taken on a cycle where req_valid && req_ready
    // (and rdy_in, and no misprediction flush); req_ready never looks at a
    // same-cycle pop. Resolve side has no ready: res_valid is a broadcast.
    assign req_ready    = (count != CNT_MAX);
    assign pred_taken   = req_valid && rdy_in && ctr[idx][1];
    assign pred_target  = pred_taken ? taken_addr : (req_valid ? fall_addr : 32'd0);
    assign match        = res_valid && rdy_in && (count != '0) && (res_pc == head.pc);
    assign predict_fail = match && (head.pred != res_taken);
    assign fail_addr    = predict_fail ? head.alt : 32'd0;
    assign pop          = match && !predict_fail;
    assign push         = req_valid && req_ready && rdy_in && !predict_fail;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            front <= '0;
            rear  <= '0;
            count <= '0;
            ghr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                queue[i] <= '0;
            end
        end else begin
            if (push) begin
                queue[rear] <= '{pc: req_pc, alt: (pred_taken ? fall_addr : taken_addr),
                                 pred: pred_taken, ix: idx, hist: ghr};
                rear <= rear + PTR_ONE;
            end
            if (predict_fail) begin
                front <= rear;
                count <= '0;
                ghr   <= ghr_fix;
            end else begin
                if (pop) begin
                    front <= front + PTR_ONE;
                end
                if (push && !pop) begin
                    count <= count + CNT_ONE;
                end else if (pop && !push) begin
                    count <= count - CNT_ONE;
                end
                if (push) begin
                    ghr <= ghr_push;
                end
            end
        end
    end

    // Counters reset to weakly not-taken; a lookup this cycle sees the old value.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (match) begin
            if (res_taken && (head_ctr != 2'b11)) begin
                ctr[head.ix] <= head_ctr + 2'd1;
            end else if (!res_taken && (head_ctr != 2'b00)) begin
                ctr[head.ix] <= head_ctr - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare: a bimodal and a gshare instance
// share stimulus; a vector table plus hand sequences cover the corner cases.
module tb_branch_predictor_gshare;
    logic        clk_in    = 1'b0;
    logic        rst_in    = 1'b0;
    logic        rdy_in    = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_pc    = '0;
    logic [31:0] req_imm   = '0;
    logic        res_valid = 1'b0;
    logic [31:0] res_pc    = '0;
    logic        res_taken = 1'b0;

    logic        b_req_ready, b_pred_taken, b_predict_fail;
    logic [31:0] b_pred_target, b_fail_addr;
    logic [3:0]  b_count;
    logic        g_req_ready, g_pred_taken, g_predict_fail;
    logic [31:0] g_pred_target, g_fail_addr;
    logic [3:0]  g_count;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        sv;
        logic [31:0] rpc;
        logic        rt;
        logic        e_taken;
        logic [31:0] e_target;
        logic        e_fail;
        logic [31:0] e_faddr;
        logic [3:0]  e_count;
    } vec_t;

    vec_t vecs[15];

    branch_predictor_gshare #(.IDX_W(6), .Q_W(3), .GHR_W(4), .GSHARE(0)) u_bim (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .req_valid(req_valid), .req_pc(req_pc), .req_imm(req_imm),
        .req_ready(b_req_ready), .pred_taken(b_pred_taken), .pred_target(b_pred_target),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
        .predict_fail(b_predict_fail), .fail_addr(b_fail_addr), .count(b_count)
    );

    branch_predictor_gshare #(.IDX_W(6), .Q_W(3), .GHR_W(4), .GSHARE(1)) u_gsh (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .req_valid(req_valid), .req_pc(req_pc), .req_imm(req_imm),
        .req_ready(g_req_ready), .pred_taken(g_pred_taken), .pred_target(g_pred_target),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
        .predict_fail(g_predict_fail), .fail_addr(g_fail_addr), .count(g_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] pc,
                         input logic [31:0] imm, input logic sv, input logic [31:0] rpc,
                         input logic rt);
        @(negedge clk_in);
        rdy_in    = rdy;
        req_valid = rv;
        req_pc    = pc;
        req_imm   = imm;
        res_valid = sv;
        res_pc    = rpc;
        res_taken = rt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in    = 1'b0;
        rdy_in    = 1'b1;
        req_valid = 1'b0;
        res_valid = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    initial begin
        //            rdy rv pc           imm          sv rpc       rt | tk target      fl faddr       cnt
        vecs[0]  = '{1, 1, 32'h100, 32'h20,       0, 32'h0,   0,  0, 32'h104, 0, 32'h0,   1};
        vecs[1]  = '{1, 0, 32'h0,   32'h0,        1, 32'h100, 1,  0, 32'h0,   1, 32'h120, 0};
        vecs[2]  = '{1, 1, 32'h100, 32'h20,       0, 32'h0,   0,  1, 32'h120, 0, 32'h0,   1};
        vecs[3]  = '{1, 0, 32'h0,   32'h0,        1, 32'h200, 0,  0, 32'h0,   0, 32'h0,   1};
        vecs[4]  = '{1, 0, 32'h0,   32'h0,        1, 32'h100, 1,  0, 32'h0,   0, 32'h0,   0};
        vecs[5]  = '{0, 1, 32'h100, 32'h20,       0, 32'h0,   0,  0, 32'h104, 0, 32'h0,   0};
        vecs[6]  = '{1, 1, 32'h104, 32'hFFFFFFF8, 0, 32'h0,   0,  0, 32'h108, 0, 32'h0,   1};
        vecs[7]  = '{1, 1, 32'h100, 32'h40,       1, 32'h104, 0,  1, 32'h140, 0, 32'h0,   1};
        vecs[8]  = '{0, 0, 32'h0,   32'h0,        1, 32'h100, 0,  0, 32'h0,   0, 32'h0,   1};
        vecs[9]  = '{1, 0, 32'h0,   32'h0,        1, 32'h100, 0,  0, 32'h0,   1, 32'h104, 0};
        vecs[10] = '{1, 1, 32'h100, 32'h20,       0, 32'h0,   0,  1, 32'h120, 0, 32'h0,   1};
        vecs[11] = '{1, 0, 32'h0,   32'h0,        1, 32'h100, 0,  0, 32'h0,   1, 32'h104, 0};
        vecs[12] = '{1, 1, 32'h100, 32'h20,       0, 32'h0,   0,  0, 32'h104, 0, 32'h0,   1};
        vecs[13] = '{1, 1, 32'h104, 32'hFFFFFFF0, 1, 32'h100, 0,  0, 32'h108, 0, 32'h0,   1};
        vecs[14] = '{1, 0, 32'h0,   32'h0,        1, 32'h104, 1,  0, 32'h0,   1, 32'hF4,  0};

        // In reset: counters read weakly not-taken, queue empty.
        #1;
        req_valid = 1'b1;
        req_pc    = 32'h100;
        req_imm   = 32'h20;
        #1;
        check("rst count", b_count, 0);
        check("rst fail", b_predict_fail, 0);
        check("rst faddr", b_fail_addr, 0);
        check("rst ready", b_req_ready, 1);
        check("rst taken", b_pred_taken, 0);
        check("rst target", b_pred_target, 32'h104);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rdy, vecs[i].rv, vecs[i].pc, vecs[i].imm,
                  vecs[i].sv, vecs[i].rpc, vecs[i].rt);
            check($sformatf("v%0d taken", i), b_pred_taken, vecs[i].e_taken);
            check($sformatf("v%0d target", i), b_pred_target, vecs[i].e_target);
            check($sformatf("v%0d fail", i), b_predict_fail, vecs[i].e_fail);
            check($sformatf("v%0d faddr", i), b_fail_addr, vecs[i].e_faddr);
            check($sformatf("v%0d ready", i), b_req_ready, 1);
            tick();
            check($sformatf("v%0d count", i), b_count, vecs[i].e_count);
        end

        // Fill the queue, stall the ninth request, then drain across the wrap.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 32'h200 + 32'(4 * i), 32'h10, 0, 0, 0);
            exp_q.push_back(req_pc);
            tick();
        end
        drive(1, 1, 32'h240, 32'h10, 0, 0, 0);
        check("full count", b_count, 8);
        check("full ready", b_req_ready, 0);
        tick();
        check("full no push", b_count, 8);
        drive(1, 1, 32'h240, 32'h10, 1, exp_q[0], 0);
        check("full pop fail", b_predict_fail, 0);
        tick();
        void'(exp_q.pop_front());
        check("no bypass count", b_count, 7);
        check("after pop ready", b_req_ready, 1);
        drive(1, 1, 32'h300, 32'h10, 0, 0, 0);
        exp_q.push_back(32'h300);
        tick();
        check("refill count", b_count, 8);
        while (exp_q.size() > 0) begin
            drive(1, 0, 0, 0, 1, exp_q[0], 0);
            check($sformatf("drain %h fail", exp_q[0]), b_predict_fail, 0);
            tick();
            void'(exp_q.pop_front());
            check("drain count", b_count, exp_q.size());
        end

        // Saturation: four taken outcomes, then walk back down.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h100, 32'h20, 0, 0, 0);
            check($sformatf("sat%0d taken", i), b_pred_taken, (i != 0));
            tick();
            drive(1, 0, 0, 0, 1, 32'h100, 1);
            check($sformatf("sat%0d fail", i), b_predict_fail, (i == 0));
            tick();
        end
        drive(1, 1, 32'h100, 32'h20, 0, 0, 0);
        check("sat11 taken", b_pred_taken, 1);
        tick();
        drive(1, 0, 0, 0, 1, 32'h100, 0);
        check("sat11 nt fail", b_predict_fail, 1);
        tick();
        drive(1, 1, 32'h100, 32'h20, 0, 0, 0);
        check("sat10 taken", b_pred_taken, 1);
        tick();
        drive(1, 0, 0, 0, 1, 32'h100, 0);
        check("sat10 nt fail", b_predict_fail, 1);
        tick();
        drive(1, 1, 32'h100, 32'h20, 0, 0, 0);
        check("sat01 taken", b_pred_taken, 0);
        tick();
        drive(1, 0, 0, 0, 1, 32'h100, 0);
        check("sat01 nt fail", b_predict_fail, 0);
        tick();
        check("sat end count", b_count, 0);

        // Mispredict with a same-cycle request; gshare history restore.
        do_reset();
        drive(1, 1, 32'h100, 32'h20, 0, 0, 0);
        tick();
        drive(1, 1, 32'h200, 32'h20, 1, 32'h100, 1);
        check("flush b fail", b_predict_fail, 1);
        check("flush g fail", g_predict_fail, 1);
        check("flush g faddr", g_fail_addr, 32'h120);
        tick();
        check("flush b count", b_count, 0);
        check("flush g count", g_count, 0);
        drive(1, 1, 32'h104, 32'h8, 0, 0, 0);
        check("ghr restore g taken", g_pred_taken, 1);
        check("ghr restore g target", g_pred_target, 32'h10C);
        check("bimodal idx1 taken", b_pred_taken, 0);
        tick();
        drive(1, 1, 32'h10C, 32'h8, 0, 0, 0);
        check("ghr shift g taken", g_pred_taken, 1);
        tick();
        check("ghr g count", g_count, 2);

        // Reset asserted with five entries in flight.
        do_reset();
        drive(1, 1, 32'h100, 32'h20, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 32'h100, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 32'h400 + 32'(4 * i), 32'h10, 0, 0, 0);
            tick();
        end
        check("mid count", b_count, 5);
        drive(1, 1, 32'h100, 32'h20, 1, 32'h400, 0);
        rst_in = 1'b0;
        #1;
        check("mid rst count", b_count, 0);
        check("mid rst fail", b_predict_fail, 0);
        check("mid rst faddr", b_fail_addr, 0);
        check("mid rst taken", b_pred_taken, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("release fail", b_predict_fail, 0);
        check("release taken", b_pred_taken, 0);
        check("release target", b_pred_target, 32'h104);
        tick();
        check("release count", b_count, 1);

        drive(1, 0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
